// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Field slices assume the default 19-bit instruction layout.
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_W_DEF = 19;
    localparam int unsigned OPC_W_DEF   = 5;
    localparam int unsigned ADDR_W_DEF  = 16;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

    localparam int unsigned FIELD_W     = 7;
    localparam int unsigned FIELD_A_MSB = 13;
    localparam int unsigned FIELD_A_LSB = 7;
    localparam int unsigned FIELD_B_MSB = 6;
    localparam int unsigned FIELD_B_LSB = 0;

    typedef enum logic {
        F_IDLE,
        F_REQ
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_program_counter.sv
// Program counter with load-over-increment priority and wrap-around.
// Commands are only honoured while i_accept is high.
module instr_fetch_unit_program_counter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_accept,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_pc_in,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;

    always_comb begin
        w_pc_nxt = r_pc;
        if (i_accept) begin
            if (i_load) begin
                w_pc_nxt = i_pc_in;
            end else if (i_inc) begin
                w_pc_nxt = r_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch responder: owns PC and IR, reads IMEM over req/ack with a timeout,
// and exposes the decoded IR fields to the control unit.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned INSTR_W  = INSTR_W_DEF,
    parameter int unsigned OPC_W    = OPC_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_load_ir,
    input  logic               i_inc_pc,
    input  logic               i_load_pc,
    input  logic [ADDR_W-1:0]  i_pc_in,
    output logic               o_im_req,
    output logic [ADDR_W-1:0]  o_im_addr,
    input  logic               i_im_ack,
    input  logic [INSTR_W-1:0] i_im_rdata,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_ir,
    output logic [OPC_W-1:0]   o_opcode,
    output logic [FIELD_W-1:0] o_field_a,
    output logic [FIELD_W-1:0] o_field_b,
    output logic               o_ir_valid,
    output logic               o_busy,
    output logic               o_fetch_err
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    fetch_state_t       r_state, w_state_nxt;
    logic               r_im_req, w_im_req_nxt;
    logic [ADDR_W-1:0]  r_im_addr, w_im_addr_nxt;
    logic [INSTR_W-1:0] r_ir, w_ir_nxt;
    logic               r_ir_valid, w_ir_valid_nxt;
    logic               r_fetch_err, w_fetch_err_nxt;
    logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
    logic [ADDR_W-1:0]  w_pc;
    logic               w_pc_accept;

    // PC commands are dropped while a fetch is outstanding or the block is disabled.
    assign w_pc_accept = i_en && (r_state == F_IDLE);

    instr_fetch_unit_program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_accept (w_pc_accept),
        .i_load   (i_load_pc),
        .i_inc    (i_inc_pc),
        .i_pc_in  (i_pc_in),
        .o_pc     (w_pc)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_im_req_nxt    = r_im_req;
        w_im_addr_nxt   = r_im_addr;
        w_ir_nxt        = r_ir;
        w_ir_valid_nxt  = r_ir_valid;
        w_tmo_cnt_nxt   = r_tmo_cnt;
        w_fetch_err_nxt = 1'b0;

        if (!i_en) begin
            w_state_nxt    = F_IDLE;
            w_im_req_nxt   = 1'b0;
            w_ir_valid_nxt = 1'b0;
            w_tmo_cnt_nxt  = '0;
        end else begin
            unique case (r_state)
                F_IDLE: begin
                    if (i_load_ir) begin
                        w_im_addr_nxt  = w_pc;
                        w_im_req_nxt   = 1'b1;
                        w_ir_valid_nxt = 1'b0;
                        w_tmo_cnt_nxt  = '0;
                        w_state_nxt    = F_REQ;
                    end
                end
                F_REQ: begin
                    // An ACK arriving on the timeout edge still completes normally.
                    if (i_im_ack) begin
                        w_ir_nxt       = i_im_rdata;
                        w_ir_valid_nxt = 1'b1;
                        w_im_req_nxt   = 1'b0;
                        w_state_nxt    = F_IDLE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        w_ir_nxt        = INSTR_W'(NOP_INSTR);
                        w_ir_valid_nxt  = 1'b0;
                        w_im_req_nxt    = 1'b0;
                        w_fetch_err_nxt = 1'b1;
                        w_state_nxt     = F_IDLE;
                    end else begin
                        w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= F_IDLE;
            r_im_req    <= 1'b0;
            r_im_addr   <= '0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_im_req    <= w_im_req_nxt;
            r_im_addr   <= w_im_addr_nxt;
            r_ir        <= w_ir_nxt;
            r_ir_valid  <= w_ir_valid_nxt;
            r_fetch_err <= w_fetch_err_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
        end
    end

    assign o_im_req    = r_im_req;
    assign o_im_addr   = r_im_addr;
    assign o_pc        = w_pc;
    assign o_ir        = r_ir;
    assign o_opcode    = r_ir[INSTR_W-1 -: OPC_W];
    assign o_field_a   = r_ir[FIELD_A_MSB:FIELD_A_LSB];
    assign o_field_b   = r_ir[FIELD_B_MSB:FIELD_B_LSB];
    assign o_ir_valid  = r_ir_valid;
    assign o_busy      = (r_state == F_REQ);
    assign o_fetch_err = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_ir;
    logic        inc_pc;
    logic        load_pc;
    logic [15:0] pc_in;
    logic        im_req;
    logic [15:0] im_addr;
    logic        im_ack;
    logic [18:0] im_rdata;
    logic [15:0] pc;
    logic [18:0] ir;
    logic [4:0]  opcode;
    logic [6:0]  field_a;
    logic [6:0]  field_b;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_load_ir   (load_ir),
        .i_inc_pc    (inc_pc),
        .i_load_pc   (load_pc),
        .i_pc_in     (pc_in),
        .o_im_req    (im_req),
        .o_im_addr   (im_addr),
        .i_im_ack    (im_ack),
        .i_im_rdata  (im_rdata),
        .o_pc        (pc),
        .o_ir        (ir),
        .o_opcode    (opcode),
        .o_field_a   (field_a),
        .o_field_b   (field_b),
        .o_ir_valid  (ir_valid),
        .o_busy      (busy),
        .o_fetch_err (fetch_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load_ir = 1'b0; inc_pc = 1'b0; load_pc = 1'b0;
        pc_in = '0; im_ack = 1'b0; im_rdata = '0;
        #1;
        check_eq("rst_pc", pc, 0);
        check_eq("rst_ir", ir, 0);
        check_eq("rst_im_req", im_req, 0);
        check_eq("rst_im_addr", im_addr, 0);
        check_eq("rst_ir_valid", ir_valid, 0);
        check_eq("rst_fetch_err", fetch_err, 0);
        check_eq("rst_busy", busy, 0);
        step(); step();
        rst = 1'b0;
        step();

        // Basic fetch, ACK in first REQ cycle.
        load_ir = 1'b1;
        step();
        load_ir = 1'b0;
        check_eq("f1_im_req", im_req, 1);
        check_eq("f1_busy", busy, 1);
        check_eq("f1_im_addr", im_addr, 16'h0000);
        check_eq("f1_ir_valid_low", ir_valid, 0);
        im_ack = 1'b1; im_rdata = 19'h5A3C1;
        step();
        im_ack = 1'b0;
        check_eq("f1_ir", ir, 19'h5A3C1);
        check_eq("f1_ir_valid", ir_valid, 1);
        check_eq("f1_opcode", opcode, 5'h16);
        check_eq("f1_field_a", field_a, 7'h47);
        check_eq("f1_field_b", field_b, 7'h41);
        check_eq("f1_im_req_drop", im_req, 0);
        check_eq("f1_busy_drop", busy, 0);

        // PC load / increment / wrap / priority.
        load_pc = 1'b1; pc_in = 16'h0100;
        step();
        load_pc = 1'b0; inc_pc = 1'b1;
        step(); step();
        inc_pc = 1'b0;
        check_eq("pc_inc2", pc, 16'h0102);
        load_pc = 1'b1; pc_in = 16'hFFFF;
        step();
        load_pc = 1'b0; inc_pc = 1'b1;
        step();
        inc_pc = 1'b0;
        check_eq("pc_wrap", pc, 16'h0000);
        load_pc = 1'b1; inc_pc = 1'b1; pc_in = 16'h1234;
        step();
        load_pc = 1'b0; inc_pc = 1'b0;
        check_eq("pc_load_prio", pc, 16'h1234);

        // Timeout: REQ held 15 cycles, then a one-cycle error pulse.
        load_ir = 1'b1;
        step();
        load_ir = 1'b0;
        check_eq("to_im_req_first", im_req, 1);
        check_eq("to_im_addr", im_addr, 16'h1234);
        for (int i = 0; i < 14; i++) begin
            step();
            check_eq("to_im_req_hold", im_req, 1);
            check_eq("to_no_err_yet", fetch_err, 0);
        end
        step();
        check_eq("to_im_req_drop", im_req, 0);
        check_eq("to_fetch_err", fetch_err, 1);
        check_eq("to_ir_nop", ir, 0);
        check_eq("to_ir_valid", ir_valid, 0);
        check_eq("to_busy", busy, 0);
        step();
        check_eq("to_err_pulse_end", fetch_err, 0);

        // ACK on the timeout edge wins.
        load_ir = 1'b1;
        step();
        load_ir = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
        end
        im_ack = 1'b1; im_rdata = 19'h12345;
        step();
        im_ack = 1'b0;
        check_eq("ta_ir", ir, 19'h12345);
        check_eq("ta_ir_valid", ir_valid, 1);
        check_eq("ta_no_err", fetch_err, 0);
        check_eq("ta_im_req", im_req, 0);

        // Commands while in REQ are ignored.
        load_ir = 1'b1;
        step();
        load_pc = 1'b1; inc_pc = 1'b1; pc_in = 16'hBEEF;
        step();
        load_ir = 1'b0; load_pc = 1'b0; inc_pc = 1'b0;
        check_eq("rq_pc_hold", pc, 16'h1234);
        check_eq("rq_im_addr_hold", im_addr, 16'h1234);
        check_eq("rq_im_req", im_req, 1);
        im_ack = 1'b1; im_rdata = 19'h7FFFF;
        step();
        im_ack = 1'b0;
        check_eq("rq_ir", ir, 19'h7FFFF);
        check_eq("rq_ir_valid", ir_valid, 1);
        step();
        check_eq("rq_no_second_req", im_req, 0);
        check_eq("rq_pc_final", pc, 16'h1234);

        // EN low mid-REQ, then a late ACK.
        load_ir = 1'b1;
        step();
        load_ir = 1'b0;
        en = 1'b0;
        step();
        check_eq("en_im_req", im_req, 0);
        check_eq("en_busy", busy, 0);
        check_eq("en_ir_hold", ir, 19'h7FFFF);
        check_eq("en_ir_valid", ir_valid, 0);
        en = 1'b1; im_ack = 1'b1; im_rdata = 19'h11111;
        step();
        im_ack = 1'b0;
        check_eq("late_ack_ir", ir, 19'h7FFFF);
        check_eq("late_ack_valid", ir_valid, 0);
        check_eq("late_ack_req", im_req, 0);

        // Asynchronous reset mid-REQ.
        load_pc = 1'b1; pc_in = 16'h0055;
        step();
        load_pc = 1'b0; load_ir = 1'b1;
        step();
        load_ir = 1'b0;
        check_eq("ar_im_req_pre", im_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_im_req", im_req, 0);
        check_eq("ar_pc", pc, 0);
        check_eq("ar_ir", ir, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_im_addr", im_addr, 0);
        step();
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
